hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//   Hazard/forwarding controller for the 5-stage pipeline. Drives the select lines of the
//   EX-stage operand mux3 instances and the ID-stage branch-compare mux2 instances.
//   Generates the stall and flush controls for load-use, branch and HI/LO hazards.
//   Sequences the multi-cycle mult/div unit with a busy FSM and down-counter.
// PARAMETERS
//   REG_AW       5   register-address width
//   MULT_CYCLES  4   mult latency in cycles, >=1
//   DIV_CYCLES   32  div latency in cycles, >=1
//   (localparam CNT_W = $clog2(max(MULT_CYCLES,DIV_CYCLES))+1)
// PORTS
//   clk            in   1       clock, rising edge
//   rst            in   1       asynchronous reset, active-high
//   id_rs, id_rt   in   REG_AW  source registers of the ID instruction
//   id_branch      in   1       ID instruction is a branch or jr
//   id_md_op       in   1       ID instruction is mult/multu/div/divu
//   id_use_hilo    in   1       ID instruction is mfhi/mflo/mthi/mtlo
//   ex_rs, ex_rt   in   REG_AW  source registers of the EX instruction
//   ex_wreg        in   REG_AW  EX destination register
//   ex_regwrite    in   1       EX writes the register file
//   ex_memtoreg    in   1       EX is a load
//   ex_md_start    in   1       EX issues a mult/div this cycle
//   ex_md_is_div   in   1       qualifies ex_md_start: 1 = div, 0 = mult
//   mem_wreg       in   REG_AW  MEM destination register
//   mem_regwrite   in   1       MEM writes the register file
//   mem_memtoreg   in   1       MEM is a load
//   wb_wreg        in   REG_AW  WB destination register
//   wb_regwrite    in   1       WB writes the register file
//   md_cancel      in   1       exception flush; aborts an in-flight mult/div
//   fwd_a_e, fwd_b_e out 2      EX mux3 select: 0 = regfile, 1 = WB, 2 = MEM
//   fwd_a_d, fwd_b_d out 1      ID mux2 select: 1 = MEM ALU result
//   stall_f, stall_d out 1      hold PC and IF/ID
//   flush_e          out 1      insert a bubble into ID/EX
//   md_busy          out 1      mult/div in progress
//   md_done          out 1      one-cycle pulse: HI/LO write enable
//   perf_stall_cnt   out 32     stall-cycle counter (see CONFIGURATION)
//   perf_md_cnt      out 32     completed mult/div counter
// BEHAVIOUR
//   - Reset: state=IDLE, cnt=0, perf counters 0. All outputs 0 while rst=1.
//   - A match means the addresses are equal and the destination register is nonzero.
//     r0 never forwards and never causes a stall.
//   - fwd_a_e: 2 if mem_regwrite and mem_wreg matches ex_rs; else 1 if wb_regwrite and
//     wb_wreg matches; else 0. MEM takes priority over WB. fwd_b_e is the same using ex_rt.
//   - fwd_a_d / fwd_b_d: mem_regwrite and mem_wreg matches id_rs / id_rt.
//   - lw_stall: ex_memtoreg and ex_wreg matches id_rs or id_rt.
//   - br_stall: id_branch and either (ex_regwrite and ex_wreg matches id_rs or id_rt)
//     or (mem_memtoreg and mem_wreg matches id_rs or id_rt).
//   - md_stall: (id_md_op or id_use_hilo) and (md_busy or ex_md_start).
//   - stall_f = stall_d = flush_e = lw_stall | br_stall | md_stall.
//     These outputs are combinational and take effect in the same cycle.
//   - FSM IDLE->BUSY: on ex_md_start & ~md_cancel, set cnt = (div ? DIV : MULT) - 1.
//   - FSM BUSY: cnt decrements each cycle. md_done = BUSY & cnt==0 & ~md_cancel.
//     Next edge after cnt==0 -> IDLE. md_busy = (state==BUSY).
//   - Latency: start sampled at edge t. md_busy is high for exactly N cycles after t.
//     md_done is high in the Nth of those cycles.
//   - md_cancel in BUSY: next edge -> IDLE, no md_done (cancel wins over a done in the same cycle).
//   - ex_md_start while BUSY cannot occur because of md_stall; if it does, it is ignored.
//   - rst mid-operation: immediately IDLE, md_busy=0, no md_done.
// CONFIGURATION
//   HAZ_PERF_EN defined: perf_stall_cnt +1 on every cycle stall_f=1.
//     perf_md_cnt +1 on every md_done. Both counters saturate at 32'hFFFFFFFF.
//   HAZ_PERF_EN undefined: both ports tied to 0 and no counter flops are built.
// TESTING
//   - EX add r3, MEM writes r3, WB writes r3 -> fwd_a_e=2. MEM r0 -> fwd_a_e=1 (WB match).
//   - ex_memtoreg=1, ex_wreg=5, id_rt=5 -> stall_f=stall_d=flush_e=1 for 1 cycle.
//     Same case with ex_wreg=0 -> no stall.
//   - id_branch=1, id_rs=4, ex_regwrite with ex_wreg=4 -> stall. Next cycle, MEM ALU r4 -> fwd_a_d=1, no stall.
//   - ex_md_start, div=0 at t -> md_busy=1 for 4 cycles, md_done at t+4.
//     id_use_hilo held high -> stalled until md_busy falls.
//   - div start, md_cancel at the 10th busy cycle -> md_busy=0 next cycle, no md_done pulse.
//   - HAZ_PERF_EN: 3 stall cycles + 2 mult -> perf_stall_cnt=3, perf_md_cnt=2.
//     Assert rst -> both 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard detection and forwarding control for the 5-stage pipeline.
//   - EX operand forwarding selects (mux3) and ID branch-compare selects (mux2)
//   - load-use, branch and HI/LO stall/flush generation
//   - busy FSM with down-counter sequencing the multi-cycle mult/div unit
// Optional feature macro: HAZ_PERF_EN builds the stall-cycle and mult/div
// completion counters; when undefined both perf ports are tied to zero and
// no counter flops exist.
//
// Mult/div handshake: ex_md_start is a one-cycle request sampled only when the
// unit is idle and md_cancel is low (a request while busy is dropped, which
// md_stall normally prevents). md_done is a one-cycle pulse in the last busy
// cycle and is the HI/LO write enable; md_cancel suppresses it and returns the
// unit to idle on the next edge.
module hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_branch,
  input  logic              id_md_op,
  input  logic              id_use_hilo,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_wreg,
  input  logic              ex_regwrite,
  input  logic              ex_memtoreg,
  input  logic              ex_md_start,
  input  logic              ex_md_is_div,
  input  logic [REG_AW-1:0] mem_wreg,
  input  logic              mem_regwrite,
  input  logic              mem_memtoreg,
  input  logic [REG_AW-1:0] wb_wreg,
  input  logic              wb_regwrite,
  input  logic              md_cancel,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              fwd_a_d,
  output logic              fwd_b_d,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_e,
  output logic              md_busy,
  output logic              md_done,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_md_cnt,
  output logic              dbg_state
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  // Counter load values: the unit is busy for N cycles, counting N-1 down to 0.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  md_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic lw_stall;
  logic br_stall;
  logic md_stall;
  logic any_stall;

  // A register match requires equal addresses and a nonzero destination:
  // r0 is hard-wired to zero, so it never forwards and never stalls.
  function automatic logic reg_match(input logic [REG_AW-1:0] src,
                                     input logic [REG_AW-1:0] dst);
    return (src == dst) && (dst != '0);
  endfunction

  // EX operand mux3 selects: MEM result (2) beats WB result (1) beats regfile (0).
  always_comb begin
    fwd_a_e = 2'd0;
    fwd_b_e = 2'd0;
    if (!rst) begin
      if (mem_regwrite && reg_match(ex_rs, mem_wreg))
        fwd_a_e = 2'd2;
      else if (wb_regwrite && reg_match(ex_rs, wb_wreg))
        fwd_a_e = 2'd1;

      if (mem_regwrite && reg_match(ex_rt, mem_wreg))
        fwd_b_e = 2'd2;
      else if (wb_regwrite && reg_match(ex_rt, wb_wreg))
        fwd_b_e = 2'd1;
    end
  end

  // ID branch-compare mux2 selects: only the MEM ALU result is forwarded here.
  always_comb begin
    fwd_a_d = 1'b0;
    fwd_b_d = 1'b0;
    if (!rst) begin
      fwd_a_d = mem_regwrite && reg_match(id_rs, mem_wreg);
      fwd_b_d = mem_regwrite && reg_match(id_rt, mem_wreg);
    end
  end

  // Hazard detection: load-use, branch operand not yet available, HI/LO busy.
  always_comb begin
    lw_stall  = 1'b0;
    br_stall  = 1'b0;
    md_stall  = 1'b0;
    any_stall = 1'b0;
    if (!rst) begin
      lw_stall = ex_memtoreg &&
                 (reg_match(id_rs, ex_wreg) || reg_match(id_rt, ex_wreg));
      // A branch resolves in ID, so an EX ALU result (not yet in MEM) or a
      // MEM load (data not available until WB) both force a wait.
      br_stall = id_branch &&
                 ((ex_regwrite && (reg_match(id_rs, ex_wreg) || reg_match(id_rt, ex_wreg))) ||
                  (mem_memtoreg && (reg_match(id_rs, mem_wreg) || reg_match(id_rt, mem_wreg))));
      md_stall = (id_md_op || id_use_hilo) && (md_busy || ex_md_start);
      any_stall = lw_stall || br_stall || md_stall;
    end
  end

  // Stall and flush are the same combined hazard, effective this cycle.
  always_comb begin
    stall_f = any_stall;
    stall_d = any_stall;
    flush_e = any_stall;
  end

  // Mult/div FSM state register and down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Mult/div FSM next state: load the latency on start, count down, and leave
  // BUSY after the cnt==0 cycle or immediately on cancel.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      MD_IDLE: begin
        if (ex_md_start && !md_cancel) begin
          state_n = MD_BUSY;
          cnt_n   = ex_md_is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      MD_BUSY: begin
        if (md_cancel || (cnt == '0)) begin
          state_n = MD_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n = MD_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Mult/div status: busy for the whole operation, done only in its last
  // cycle and never in a cycle where it is being cancelled.
  always_comb begin
    md_busy   = (state == MD_BUSY);
    md_done   = (state == MD_BUSY) && (cnt == '0) && !md_cancel;
    dbg_state = state;
  end

`ifdef HAZ_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] md_cnt_q;

  // Saturating performance counters: stall cycles and completed mult/div ops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      md_cnt_q    <= '0;
    end else begin
      if (stall_f && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (md_done && (md_cnt_q != 32'hFFFF_FFFF))
        md_cnt_q <= md_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_md_cnt    = md_cnt_q;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_md_cnt    = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against a
// behavioural model. Mult/div operations are modelled as a queue of expected
// completion cycles; hazards and forwarding are computed from the rules.
module tb_hazard_ctrl;

  localparam int AW = 5;
  localparam int MC = 4;
  localparam int DC = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_wreg, mem_wreg, wb_wreg;
  logic          id_branch, id_md_op, id_use_hilo;
  logic          ex_regwrite, ex_memtoreg, ex_md_start, ex_md_is_div;
  logic          mem_regwrite, mem_memtoreg, wb_regwrite, md_cancel;
  logic [1:0]    fwd_a_e, fwd_b_e;
  logic          fwd_a_d, fwd_b_d, stall_f, stall_d, flush_e, md_busy, md_done;
  logic [31:0]   perf_stall_cnt, perf_md_cnt;
  logic          dbg_state;

  int tests = 0;
  int fails = 0;

  // Model state: expected completion cycle of the in-flight op (at most one).
  logic [31:0] exp_q[$];
  logic [31:0] cyc = 32'd0;
  logic [31:0] m_stall_cnt = 32'd0;
  logic [31:0] m_md_cnt = 32'd0;

  hazard_ctrl #(.REG_AW(AW), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_branch(id_branch), .id_md_op(id_md_op),
    .id_use_hilo(id_use_hilo),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg), .ex_regwrite(ex_regwrite),
    .ex_memtoreg(ex_memtoreg), .ex_md_start(ex_md_start), .ex_md_is_div(ex_md_is_div),
    .mem_wreg(mem_wreg), .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
    .wb_wreg(wb_wreg), .wb_regwrite(wb_regwrite), .md_cancel(md_cancel),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .md_busy(md_busy), .md_done(md_done),
    .perf_stall_cnt(perf_stall_cnt), .perf_md_cnt(perf_md_cnt),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic hit(input logic [AW-1:0] src, input logic [AW-1:0] dst);
    return (src == dst) && (dst != 0);
  endfunction

  function automatic logic [1:0] m_fwd_e(input logic [AW-1:0] src);
    if (rst) return 2'd0;
    if (mem_regwrite && hit(src, mem_wreg)) return 2'd2;
    if (wb_regwrite && hit(src, wb_wreg)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic m_fwd_d(input logic [AW-1:0] src);
    return !rst && mem_regwrite && hit(src, mem_wreg);
  endfunction

  function automatic logic m_busy();
    return !rst && (exp_q.size() != 0);
  endfunction

  function automatic logic m_done();
    if (!m_busy()) return 1'b0;
    return (exp_q[0] == cyc) && !md_cancel;
  endfunction

  function automatic logic m_stall();
    logic lw, br, md;
    if (rst) return 1'b0;
    lw = ex_memtoreg && (hit(id_rs, ex_wreg) || hit(id_rt, ex_wreg));
    br = id_branch && ((ex_regwrite && (hit(id_rs, ex_wreg) || hit(id_rt, ex_wreg))) ||
                       (mem_memtoreg && (hit(id_rs, mem_wreg) || hit(id_rt, mem_wreg))));
    md = (id_md_op || id_use_hilo) && (m_busy() || ex_md_start);
    return lw || br || md;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_stall_cnt = 32'd0;
    m_md_cnt    = 32'd0;
  endtask

  // Advance the model across one rising edge using the inputs held at that edge.
  task automatic model_edge();
    logic was_busy, st, dn;
    if (rst) begin
      model_clear();
    end else begin
      was_busy = exp_q.size() != 0;
      st = m_stall();
      dn = m_done();
      if (st && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
      if (dn && m_md_cnt != 32'hFFFF_FFFF) m_md_cnt++;
      if (was_busy && (md_cancel || exp_q[0] == cyc)) void'(exp_q.pop_front());
      cyc++;
      if (!was_busy && ex_md_start && !md_cancel)
        exp_q.push_back(cyc + (ex_md_is_div ? DC : MC) - 1);
    end
  endtask

  task automatic check_all();
    logic [31:0] exp_ps, exp_pm;
`ifdef HAZ_PERF_EN
    exp_ps = m_stall_cnt;
    exp_pm = m_md_cnt;
`else
    exp_ps = 32'd0;
    exp_pm = 32'd0;
`endif
    check("fwd_a_e", fwd_a_e, m_fwd_e(ex_rs));
    check("fwd_b_e", fwd_b_e, m_fwd_e(ex_rt));
    check("fwd_a_d", fwd_a_d, m_fwd_d(id_rs));
    check("fwd_b_d", fwd_b_d, m_fwd_d(id_rt));
    check("stall_f", stall_f, m_stall());
    check("stall_d", stall_d, m_stall());
    check("flush_e", flush_e, m_stall());
    check("md_busy", md_busy, m_busy());
    check("dbg_state", dbg_state, m_busy());
    check("md_done", md_done, m_done());
    check("perf_stall_cnt", perf_stall_cnt, exp_ps);
    check("perf_md_cnt", perf_md_cnt, exp_pm);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; id_branch = 0; id_md_op = 0; id_use_hilo = 0;
    ex_rs = 0; ex_rt = 0; ex_wreg = 0; ex_regwrite = 0; ex_memtoreg = 0;
    ex_md_start = 0; ex_md_is_div = 0;
    mem_wreg = 0; mem_regwrite = 0; mem_memtoreg = 0;
    wb_wreg = 0; wb_regwrite = 0; md_cancel = 0;
  endtask

  task automatic random_inputs();
    id_rs = AW'($urandom_range(0, 7)); id_rt = AW'($urandom_range(0, 7));
    ex_rs = AW'($urandom_range(0, 7)); ex_rt = AW'($urandom_range(0, 7));
    ex_wreg = AW'($urandom_range(0, 7)); mem_wreg = AW'($urandom_range(0, 7));
    wb_wreg = AW'($urandom_range(0, 7));
    id_branch    = ($urandom_range(0, 3) == 0);
    id_md_op     = ($urandom_range(0, 7) == 0);
    id_use_hilo  = ($urandom_range(0, 7) == 0);
    ex_regwrite  = ($urandom_range(0, 1) == 0);
    ex_memtoreg  = ($urandom_range(0, 3) == 0);
    ex_md_start  = ($urandom_range(0, 7) == 0);
    ex_md_is_div = ($urandom_range(0, 3) == 0);
    mem_regwrite = ($urandom_range(0, 1) == 0);
    mem_memtoreg = ($urandom_range(0, 3) == 0);
    wb_regwrite  = ($urandom_range(0, 1) == 0);
    md_cancel    = ($urandom_range(0, 39) == 0);
  endtask

  // One cycle: inputs were driven at the falling edge; check, clock, return
  // at the next falling edge.
  task automatic tick();
    #1;
    if (rst) model_clear();
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int busy_cycles, done_cnt, done_at;

    rst = 1'b1;
    idle_inputs();
    @(negedge clk);

    // Reset: outputs held at zero even with hazard-producing inputs.
    ex_rs = 3; mem_wreg = 3; mem_regwrite = 1;
    ex_memtoreg = 1; ex_wreg = 5; id_rt = 5; ex_md_start = 1;
    #1;
    check("rst_fwd_a_e", fwd_a_e, 32'd0);
    check("rst_stall_f", stall_f, 32'd0);
    check("rst_md_busy", md_busy, 32'd0);
    tick();
    rst = 1'b0;
    idle_inputs();
    tick();

    // Forwarding priority: MEM over WB, and MEM r0 falls back to WB.
    ex_rs = 3; ex_rt = 9; ex_regwrite = 1;
    mem_regwrite = 1; mem_wreg = 3; wb_regwrite = 1; wb_wreg = 3;
    #1;
    check("fwd_mem_prio", fwd_a_e, 32'd2);
    check("fwd_b_none", fwd_b_e, 32'd0);
    tick();
    mem_wreg = 0;
    #1;
    check("fwd_mem_r0_wb", fwd_a_e, 32'd1);
    tick();
    idle_inputs();

    // Load-use stall, then the r0 variant that must not stall.
    ex_memtoreg = 1; ex_wreg = 5; id_rt = 5;
    #1;
    check("lw_stall_f", stall_f, 32'd1);
    check("lw_flush_e", flush_e, 32'd1);
    tick();
    ex_wreg = 0; id_rt = 0;
    #1;
    check("lw_r0_nostall", stall_f, 32'd0);
    tick();
    idle_inputs();

    // Branch on an EX result: stall, then forward from MEM next cycle.
    id_branch = 1; id_rs = 4; ex_regwrite = 1; ex_wreg = 4;
    #1;
    check("br_stall", stall_d, 32'd1);
    tick();
    ex_regwrite = 0; ex_wreg = 0; mem_regwrite = 1; mem_wreg = 4;
    #1;
    check("br_fwd_a_d", fwd_a_d, 32'd1);
    check("br_nostall", stall_d, 32'd0);
    tick();
    idle_inputs();

    // Mult: busy for MC cycles, done in the last; HI/LO reader stalls meanwhile.
    ex_md_start = 1; ex_md_is_div = 0;
    tick();
    idle_inputs();
    id_use_hilo = 1;
    busy_cycles = 0; done_cnt = 0; done_at = 0;
    for (int i = 1; i <= 40; i++) begin
      #1;
      if (!md_busy) break;
      busy_cycles++;
      if (md_done) begin done_cnt++; done_at = i; end
      tick();
    end
    check("mult_busy_cycles", busy_cycles, MC);
    check("mult_done_cnt", done_cnt, 32'd1);
    check("mult_done_at", done_at, MC);
    check("hilo_release", stall_f, 32'd0);
    tick();
    idle_inputs();

    // Div cancelled in its 10th busy cycle: no done pulse, idle next cycle.
    ex_md_start = 1; ex_md_is_div = 1;
    tick();
    idle_inputs();
    busy_cycles = 0; done_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      #1;
      if (!md_busy) break;
      busy_cycles++;
      if (md_done) done_cnt++;
      md_cancel = (busy_cycles == 10);
      tick();
      md_cancel = 0;
    end
    check("div_cancel_busy", busy_cycles, 32'd10);
    check("div_cancel_done", done_cnt, 32'd0);
    tick();

    // Reset in the middle of an operation clears busy immediately.
    ex_md_start = 1; ex_md_is_div = 1;
    tick();
    idle_inputs();
    tick();
    tick();
    rst = 1;
    #1;
    check("rst_mid_busy", md_busy, 32'd0);
    check("rst_mid_done", md_done, 32'd0);
    tick();
    rst = 0;
    tick();

    // Perf counters: 3 stall cycles and 2 mults from a clean reset.
    rst = 1;
    tick();
    rst = 0;
    ex_memtoreg = 1; ex_wreg = 6; id_rs = 6;
    for (int i = 0; i < 3; i++) tick();
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      ex_md_start = 1;
      tick();
      ex_md_start = 0;
      for (int i = 0; i < MC + 1; i++) tick();
    end
    #1;
`ifdef HAZ_PERF_EN
    check("perf_stall_3", perf_stall_cnt, 32'd3);
    check("perf_md_2", perf_md_cnt, 32'd2);
`else
    check("perf_stall_off", perf_stall_cnt, 32'd0);
    check("perf_md_off", perf_md_cnt, 32'd0);
`endif
    rst = 1;
    #1;
    check("perf_stall_rst", perf_stall_cnt, 32'd0);
    check("perf_md_rst", perf_md_cnt, 32'd0);
    tick();
    rst = 0;
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      random_inputs();
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 0;
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
